// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the binary-to-BCD display path.
package bcd_disp_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

  localparam int         BCD_DIGIT_W     = 4;
  localparam logic [3:0] BCD_ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the shift,
// so that doubling it carries cleanly into the next decimal digit.
module bcd_add3
  import bcd_disp_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_in,
  output logic [BCD_DIGIT_W-1:0] digit_out
);

  always_comb begin
    digit_out = (digit_in >= BCD_ADD3_THRESH) ? digit_in + 4'd3 : digit_in;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one correct-and-shift step per clock,
// with a start/ready/done handshake and results held between conversions.
module bin_to_bcd_seq
  import bcd_disp_pkg::*;
#(
  parameter  int DATA_WIDTH = 20,
  parameter  int NUM_DIGITS = 6,
  localparam int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [DATA_WIDTH-1:0]             bin_in,
  output logic                              ready,
  output logic                              busy,
  output logic                              done,
  output logic [BCD_DIGIT_W*NUM_DIGITS-1:0] bcd_out,
  output logic                              overflow,
  output logic [NUM_DIGITS-1:0]             lz_mask
);

  localparam int BCD_W = BCD_DIGIT_W * NUM_DIGITS;

  bcd_state_t            state;
  logic [CNT_W-1:0]      count;
  logic [DATA_WIDTH-1:0] bin_sr;
  logic [BCD_W-1:0]      bcd_sr;
  logic                  sticky;

  logic [BCD_W-1:0]      bcd_corr;
  logic [BCD_W-1:0]      bcd_nxt;
  logic [DATA_WIDTH-1:0] bin_nxt;
  logic                  step_carry;
  logic [NUM_DIGITS-1:0] lz_nxt;
  logic                  last_step;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_in  (bcd_sr[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_out (bcd_corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Whatever leaves the top digit's MSB means the value did not fit the digits.
  assign {step_carry, bcd_nxt, bin_nxt} = {bcd_corr, bin_sr, 1'b0};
  assign last_step = (count == CNT_W'(DATA_WIDTH - 1));

  // Leading-zero mask from the final step value; the units digit is never blanked.
  always_comb begin
    logic any_nz;
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    lz_nxt = '0;
    any_nz = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      any_nz    = any_nz | (bcd_nxt[i*BCD_DIGIT_W +: BCD_DIGIT_W] != '0);
      lz_nxt[i] = ~any_nz;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
      lz_mask  <= '0;
      count    <= '0;
      bin_sr   <= '0;
      bcd_sr   <= '0;
      sticky   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr <= bin_in;
            bcd_sr <= '0;
            sticky <= 1'b0;
            count  <= '0;
            ready  <= 1'b0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_sr <= bcd_nxt;
          bin_sr <= bin_nxt;
          sticky <= sticky | step_carry;
          count  <= count + 1'b1;
          if (last_step) begin
            bcd_out  <= bcd_nxt;
            overflow <= sticky | step_carry;
            lz_mask  <= lz_nxt;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench: stimulus pushes hand-computed results into a scoreboard,
// an independent monitor pops and compares on every done pulse.
module tb_bin_to_bcd_seq;

  localparam int DW = 20;
  localparam int ND = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [DW-1:0] bin_in;
  logic          ready, busy, done, overflow;
  logic [4*ND-1:0] bcd_out;
  logic [ND-1:0]   lz_mask;

  bin_to_bcd_seq #(.DATA_WIDTH(DW), .NUM_DIGITS(ND)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bin_in   (bin_in),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .overflow (overflow),
    .lz_mask  (lz_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [23:0] bcd;
    logic        ovf;
    logic [5:0]  lz;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, "_bcd"}, 32'(bcd_out), 32'(e.bcd));
        check({e.name, "_ovf"}, 32'(overflow), 32'(e.ovf));
        check({e.name, "_lz"},  32'(lz_mask), 32'(e.lz));
      end
    end
  end

  // Counts edges until done is seen #1 after an edge; bounded.
  task automatic wait_done(input string name, output int edges);
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (!done && edges < 100);
    if (!done) check({name, "_timeout"}, 32'(done), 32'd1);
  endtask

  // One conversion; ign>0 injects a start with bin_in=777 sampled on SHIFT edge ign.
  task automatic convert(input string name, input logic [DW-1:0] v,
                         input logic [23:0] e_bcd, input logic e_ovf,
                         input logic [5:0] e_lz, input int ign);
    exp_t e;
    int   edges;
    e.name = name; e.bcd = e_bcd; e.ovf = e_ovf; e.lz = e_lz;
    sb_q.push_back(e);
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    @(posedge clk); #1;
    start  = 1'b0;
    bin_in = '1;
    check({name, "_ready_low"}, 32'(ready), 32'd0);
    check({name, "_busy_high"}, 32'(busy), 32'd1);
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
      if (ign != 0 && edges == ign - 1) begin
        start  = 1'b1;
        bin_in = 20'd777;
      end else begin
        start = 1'b0;
      end
    end while (!done && edges < 100);
    start = 1'b0;
    if (!done) check({name, "_timeout"}, 32'(done), 32'd1);
    check({name, "_latency"}, 32'(edges), 32'(DW));
    check({name, "_busy_in_done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    check({name, "_done_one_cycle"}, 32'(done), 32'd0);
    check({name, "_ready_back"}, 32'(ready), 32'd1);
  endtask

  initial begin
    exp_t e;
    int   e1, e2;
    reset  = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_bcd",   32'(bcd_out), 32'd0);
    check("rst_ovf",   32'(overflow), 32'd0);
    check("rst_lz",    32'(lz_mask), 32'd0);
    reset = 1'b0;

    convert("zero",    20'd0,       24'h000000, 1'b0, 6'b111110, 0);
    convert("v255",    20'd255,     24'h000255, 1'b0, 6'b111000, 0);
    convert("v999999", 20'd999999,  24'h999999, 1'b0, 6'b000000, 0);
    convert("v1e6",    20'd1000000, 24'h000000, 1'b1, 6'b111110, 0);
    convert("vmax",    20'd1048575, 24'h048575, 1'b1, 6'b100000, 0);
    convert("ignored", 20'd123456,  24'h123456, 1'b0, 6'b000000, 5);

    // Start held high: back-to-back conversions at the minimum period.
    e.name = "b2b"; e.bcd = 24'h000042; e.ovf = 1'b0; e.lz = 6'b111100;
    sb_q.push_back(e);
    sb_q.push_back(e);
    @(negedge clk);
    start  = 1'b1;
    bin_in = 20'd42;
    wait_done("b2b_first", e1);
    check("b2b_first_latency", 32'(e1), 32'(DW + 1));
    wait_done("b2b_second", e2);
    start = 1'b0;
    check("b2b_period", 32'(e2), 32'(DW + 2));
    repeat (3) @(posedge clk);

    // Reset on SHIFT step 10 aborts the conversion with no done pulse.
    @(negedge clk);
    start  = 1'b1;
    bin_in = 20'd54321;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_busy",  32'(busy), 32'd0);
    check("abort_done",  32'(done), 32'd0);
    check("abort_bcd",   32'(bcd_out), 32'd0);
    check("abort_ovf",   32'(overflow), 32'd0);
    repeat (25) @(posedge clk);
    convert("after_abort", 20'd54321, 24'h054321, 1'b0, 6'b100000, 0);

    repeat (3) @(posedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using double-dabble: one shift/correct step per clock.
- Producer side of the seven-segment display path. It turns a binary value (counter, register readout) into packed BCD digits.
- Each digit feeds one per-digit seven-segment decoder (dig_displ_7_segs) on the DE10-Lite HEX displays.
- Start/ready/done handshake. Results are held stable between conversions.

Parameters:
- DATA_WIDTH, 20, width of the unsigned binary input.
- NUM_DIGITS, 6, number of BCD output digits (DE10-Lite HEX0..HEX5).
- CNT_W, $clog2(DATA_WIDTH+1), width of the internal step counter (derived, not overridden).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a conversion; accepted only when ready=1.
- bin_in  input  DATA_WIDTH  unsigned value, sampled on the accepting edge.
- ready  output  1  converter idle, start will be accepted.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse: bcd_out/overflow/lz_mask just updated.
- bcd_out  output  4*NUM_DIGITS  packed BCD; digit i at bits [4i+3:4i], digit 0 = units.
- overflow  output  1  bin_in exceeded 10^NUM_DIGITS-1 in the last conversion.
- lz_mask  output  NUM_DIGITS  bit i=1: digit i is a leading zero (blankable); bit 0 always 0.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset. Reset has priority over everything.
- Reset values: state=IDLE, ready=1, busy=0, done=0, bcd_out=0, overflow=0, lz_mask=0. Internal scratch and counter are cleared.
- State machine with states IDLE, SHIFT, DONE:
  - IDLE: ready=1. If start=1 at edge k, latch bin_in into the shift register, clear the BCD scratch and sticky carry, set count=0, go to SHIFT.
  - SHIFT: busy=1. Each edge performs one step:
    - every scratch digit >=5 gets +3;
    - the scratch {digits, bin} is shifted left 1; the bin MSB enters digit 0 LSB;
    - the bit shifted out of the top digit's MSB is ORed into a sticky carry;
    - count increments.
  - SHIFT exit: on the edge where count reaches DATA_WIDTH-1 (edge k+DATA_WIDTH), the final step result loads bcd_out, overflow and lz_mask directly, and the state goes to DONE.
  - DONE: done=1, ready=0, busy=0, for exactly one cycle. Unconditionally returns to IDLE.
- Latency:
  - done is high in the cycle after edge k+DATA_WIDTH.
  - ready returns after edge k+DATA_WIDTH+1.
  - With start held high, the minimum conversion period is DATA_WIDTH+2 cycles.
- start while ready=0 (SHIFT or DONE) is ignored: no queueing, no effect on the current conversion.
- bin_in changes after the accepting edge have no effect.
- Results:
  - bcd_out = bin_in mod 10^NUM_DIGITS; every digit is always a valid 0..9.
  - overflow = sticky carry, i.e. 1 iff bin_in >= 10^NUM_DIGITS.
  - bcd_out, overflow and lz_mask change only on the DONE-entry edge or on reset, and hold otherwise.
- lz_mask, for i>=1: bit i = 1 iff digits NUM_DIGITS-1 down to i are all zero. It is computed from the final value.
- Reset mid-conversion: abort, go to IDLE, clear outputs, no done pulse.
- Width rule: all digit correction is 4-bit unsigned. The +3 is applied before the shift, never after.

Decomposition:
- Package bcd_disp_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;
  - constant BCD_DIGIT_W=4;
  - constant BCD_ADD3_THRESH=4'd5.
- Sub-module bcd_add3: combinational 4-bit "if >=5 then +3" digit correction, instantiated NUM_DIGITS times via generate.
- Step counter and FSM live in the top module.

Test Plan:
- Reset, then start with bin_in=0:
  - done pulses exactly DATA_WIDTH+1 cycles after start was sampled high;
  - bcd_out=24'h000000, overflow=0, lz_mask=6'b111110.
- bin_in=255 → bcd_out=24'h000255, lz_mask=6'b111000, overflow=0.
- bin_in=999999 → bcd_out=24'h999999, overflow=0, lz_mask=6'b000000.
- Overflow cases:
  - bin_in=1000000 → bcd_out=24'h000000, overflow=1;
  - bin_in=1048575 → bcd_out=24'h048575, overflow=1.
- Handshake and back-to-back:
  - convert 123456; assert start with bin_in=777 on cycle 5 of SHIFT → ignored, result is 24'h123456;
  - start held high with bin_in=42 → next done exactly 22 cycles after the previous one, with 24'h000042.
- Reset mid-conversion:
  - start bin_in=54321, assert reset on step 10 → next cycle ready=1, bcd_out=0, no done;
  - a following conversion of 54321 → 24'h054321.
